// File: rtl/lcplc_frame_sequencer_if.sv
// Stream bundle for the frame sequencer: raw samples in (s_*) and
// coder-ordered samples with framing flags out (x_*).
interface lcplc_frame_sequencer_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  s_valid;
  logic                  s_ready;
  logic [DATA_WIDTH-1:0] s_data;
  logic                  s_last;
  logic                  x_valid;
  logic                  x_ready;
  logic [DATA_WIDTH-1:0] x_data;
  logic                  x_last_r;
  logic                  x_last_s;
  logic                  x_last_b;
  logic                  x_last_i;

  modport master (
    output s_valid, s_data, s_last, x_ready,
    input  s_ready, x_valid, x_data, x_last_r, x_last_s, x_last_b, x_last_i
  );

  modport slave (
    input  s_valid, s_data, s_last, x_ready,
    output s_ready, x_valid, x_data, x_last_r, x_last_s, x_last_b, x_last_i
  );
endinterface

// File: rtl/lcplc_frame_sequencer.sv
// Band-sequential frame sequencer: tags each sample with row/slice/block/image-last
// flags through a one-deep output register. LCPLC_SEQ_LAST_CHECK_EN enables s_last checking.
module lcplc_frame_sequencer #(
  parameter int DATA_WIDTH      = 16,
  parameter int BLOCK_SIZE_LOG  = 4,
  parameter int BAND_WIDTH      = 10,
  parameter int BLOCK_CNT_WIDTH = 12
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cfg_start,
  input  logic [BLOCK_SIZE_LOG-1:0]  cfg_width_m1,
  input  logic [BLOCK_SIZE_LOG-1:0]  cfg_height_m1,
  input  logic [BAND_WIDTH-1:0]      cfg_bands_m1,
  input  logic [BLOCK_CNT_WIDTH-1:0] cfg_blocks_m1,
  lcplc_frame_sequencer_if.slave     io,
  output logic                       busy,
  output logic                       done,
  output logic                       err
);
  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t                     state, state_nxt;
  logic [BLOCK_SIZE_LOG-1:0]  w_m1, h_m1, col, row;
  logic [BAND_WIDTH-1:0]      bands_m1, band;
  logic [BLOCK_CNT_WIDTH-1:0] blocks_m1, block;
  logic [DATA_WIDTH-1:0]      x_data_q;
  logic                       x_vld, lr_q, ls_q, lb_q, li_q;
  logic                       col_end, row_end, band_end, img_last;
  logic                       s_hs, x_hs, cfg_go, done_nxt;

  assign col_end  = (col == w_m1);
  assign row_end  = col_end && (row == h_m1);
  assign band_end = row_end && (band == bands_m1);
  assign img_last = band_end && (block == blocks_m1);

  // Handshakes are masked while reset is low so nothing moves during reset.
  assign io.s_ready = rst && (state == RUN) && (!x_vld || io.x_ready);
  assign io.x_valid = rst && x_vld;
  assign io.x_data   = x_data_q;
  assign io.x_last_r = lr_q;
  assign io.x_last_s = ls_q;
  assign io.x_last_b = lb_q;
  assign io.x_last_i = li_q;

  assign s_hs   = io.s_valid && io.s_ready;
  assign x_hs   = io.x_valid && io.x_ready;
  assign cfg_go = (state == IDLE) && cfg_start;
  assign busy   = (state != IDLE);

  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    case (state)
      IDLE:  if (cfg_start) state_nxt = RUN;
      RUN:   if (s_hs && img_last) state_nxt = FLUSH;
      FLUSH: if (x_hs && li_q) begin
        state_nxt = IDLE;
        done_nxt  = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      done      <= 1'b0;
      w_m1      <= '0;
      h_m1      <= '0;
      bands_m1  <= '0;
      blocks_m1 <= '0;
      col       <= '0;
      row       <= '0;
      band      <= '0;
      block     <= '0;
      x_vld     <= 1'b0;
      x_data_q  <= '0;
      lr_q      <= 1'b0;
      ls_q      <= 1'b0;
      lb_q      <= 1'b0;
      li_q      <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= done_nxt;
      if (cfg_go) begin
        w_m1      <= cfg_width_m1;
        h_m1      <= cfg_height_m1;
        bands_m1  <= cfg_bands_m1;
        blocks_m1 <= cfg_blocks_m1;
        col       <= '0;
        row       <= '0;
        band      <= '0;
        block     <= '0;
      end else if (s_hs) begin
        // col fastest, then row, then band, then block
        if (!col_end)            col   <= col + BLOCK_SIZE_LOG'(1);
        else begin
          col <= '0;
          if (!row_end)          row   <= row + BLOCK_SIZE_LOG'(1);
          else begin
            row <= '0;
            if (!band_end)       band  <= band + BAND_WIDTH'(1);
            else begin
              band  <= '0;
              block <= img_last ? '0 : block + BLOCK_CNT_WIDTH'(1);
            end
          end
        end
      end
      // Load wins over drain so an accept and drain in one cycle keeps the new sample.
      if (s_hs) begin
        x_vld    <= 1'b1;
        x_data_q <= io.s_data;
        lr_q     <= col_end;
        ls_q     <= row_end;
        lb_q     <= band_end;
        li_q     <= img_last;
      end else if (x_hs) begin
        x_vld <= 1'b0;
      end
    end
  end

`ifdef LCPLC_SEQ_LAST_CHECK_EN
  always_ff @(posedge clk) begin
    if (!rst)                               err <= 1'b0;
    else if (cfg_go)                        err <= 1'b0;
    else if (s_hs && (io.s_last != img_last)) err <= 1'b1;
  end
`else
  logic unused_s_last;
  assign unused_s_last = io.s_last;
  assign err = 1'b0;
`endif
endmodule

// File: tb/tb_lcplc_frame_sequencer.sv
// Scoreboard bench for lcplc_frame_sequencer: expected samples/flags are queued as
// stimulus is driven and popped as the coder side accepts them.
module tb_lcplc_frame_sequencer;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cfg_start = 1'b0;
  logic [3:0]  cfg_w = '0, cfg_h = '0;
  logic [9:0]  cfg_b = '0;
  logic [11:0] cfg_k = '0;
  logic        busy, done, err;

  lcplc_frame_sequencer_if #(.DATA_WIDTH(16)) sif();

  lcplc_frame_sequencer #(
    .DATA_WIDTH(16), .BLOCK_SIZE_LOG(4), .BAND_WIDTH(10), .BLOCK_CNT_WIDTH(12)
  ) u_dut (
    .clk(clk), .rst(rst), .cfg_start(cfg_start),
    .cfg_width_m1(cfg_w), .cfg_height_m1(cfg_h),
    .cfg_bands_m1(cfg_b), .cfg_blocks_m1(cfg_k),
    .io(sif), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

`ifdef LCPLC_SEQ_LAST_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  typedef struct packed {
    logic [15:0] d;
    logic r, s, b, i;
  } exp_t;
  exp_t exp_q[$];
  int   acc_q[$];

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic pulse_cfg(input int w, input int h, input int nb, input int nk);
    cfg_w = 4'(w - 1); cfg_h = 4'(h - 1); cfg_b = 10'(nb - 1); cfg_k = 12'(nk - 1);
    cfg_start = 1'b1;
    tick;
    cfg_start = 1'b0;
  endtask

  // Runs one image; err_at injects a wrong s_last, cfg_at pulses a stray cfg_start.
  task automatic test_frame(input string tag, input int w, input int h, input int nb,
                            input int nk, input bit stall, input int err_at,
                            input int cfg_at, input bit fixed, input logic [15:0] fdata);
    int n_total;
    n_total = w * h * nb * nk;
    exp_q.delete();
    acc_q.delete();
    pulse_cfg(w, h, nb, nk);
    total++;
    if (busy !== 1'b1 || err !== 1'b0) begin
      bad++;
      $display("FAIL %s start busy/err got=%b%b exp=10", tag, busy, err);
    end
    fork
      begin : drv
        int idx = 0;
        for (int k = 0; k < nk; k++)
          for (int bd = 0; bd < nb; bd++)
            for (int r = 0; r < h; r++)
              for (int c = 0; c < w; c++) begin
                exp_t e;
                bit acc;
                bit exp_err;
                int n;
                e.d = fixed ? fdata : 16'($urandom);
                e.r = (c == w - 1);
                e.s = e.r && (r == h - 1);
                e.b = e.s && (bd == nb - 1);
                e.i = e.b && (k == nk - 1);
                exp_q.push_back(e);
                if (stall)
                  while ($urandom_range(0, 2) == 0) begin sif.s_valid = 1'b0; tick; end
                sif.s_valid = 1'b1;
                sif.s_data  = e.d;
                sif.s_last  = (idx == err_at) ? ~e.i : e.i;
                if (idx == cfg_at) begin
                  cfg_start = 1'b1; cfg_w = 4'd0; cfg_h = 4'd1; cfg_b = 10'd0; cfg_k = 12'd0;
                end
                acc = 1'b0;
                n = 0;
                while (!acc && n < 200) begin
                  @(negedge clk);
                  acc = sif.s_ready;
                  if (acc) acc_q.push_back(cyc);
                  @(posedge clk); #1;
                  cfg_start = 1'b0;
                  n++;
                end
                total++;
                if (!acc) begin
                  bad++;
                  $display("FAIL %s s_ready timeout sample=%0d got=0 exp=1", tag, idx);
                end
                exp_err = CHK && (err_at >= 0) && (idx >= err_at);
                total++;
                if (err !== exp_err) begin
                  bad++;
                  $display("FAIL %s err sample=%0d got=%b exp=%b", tag, idx, err, exp_err);
                end
                idx++;
              end
        sif.s_valid = 1'b0;
        sif.s_last  = 1'b0;
      end
      begin : mon
        int   n_rx = 0;
        int   guard = 0;
        bit   prev_stall = 1'b0;
        exp_t pv = '0;
        exp_t got;
        while (n_rx < n_total && guard < 3000) begin
          sif.x_ready = stall ? ((cyc % 3) != 0) : 1'b1;
          @(negedge clk);
          got = {sif.x_data, sif.x_last_r, sif.x_last_s, sif.x_last_b, sif.x_last_i};
          if (prev_stall) begin
            total++;
            if (sif.x_valid !== 1'b1 || got !== pv) begin
              bad++;
              $display("FAIL %s stall hold got=%b/%h exp=1/%h", tag, sif.x_valid, got, pv);
            end
          end
          if (sif.x_valid && sif.x_ready) begin
            exp_t e;
            int a;
            e = exp_q.pop_front();
            a = acc_q.pop_front();
            total++;
            if (got !== e) begin
              bad++;
              $display("FAIL %s out #%0d got=%h exp=%h", tag, n_rx + 1, got, e);
            end
            if (!stall) begin
              total++;
              if (cyc !== a + 1) begin
                bad++;
                $display("FAIL %s latency #%0d got=%0d exp=1", tag, n_rx + 1, cyc - a);
              end
            end
            if (e.i) begin
              total++;
              if (done !== 1'b0) begin
                bad++;
                $display("FAIL %s early done got=%b exp=0", tag, done);
              end
            end
            n_rx++;
          end
          prev_stall = sif.x_valid && !sif.x_ready;
          pv = got;
          @(posedge clk); #1;
          guard++;
        end
        total++;
        if (n_rx != n_total) begin
          bad++;
          $display("FAIL %s output count got=%0d exp=%0d", tag, n_rx, n_total);
        end
        @(negedge clk);
        total++;
        if (done !== 1'b1 || busy !== 1'b0 || sif.x_valid !== 1'b0) begin
          bad++;
          $display("FAIL %s end done/busy/x_valid got=%b%b%b exp=100", tag, done, busy, sif.x_valid);
        end
        tick;
        total++;
        if (done !== 1'b0) begin
          bad++;
          $display("FAIL %s done width got=%b exp=0", tag, done);
        end
      end
    join
  endtask

  task automatic test_reset;
    rst = 1'b0; cfg_start = 1'b1; sif.s_valid = 1'b1; sif.x_ready = 1'b1;
    sif.s_data = 16'h1234; sif.s_last = 1'b0;
    tick; tick;
    total++;
    if ({sif.x_valid, sif.x_data, sif.x_last_r, sif.x_last_s, sif.x_last_b, sif.x_last_i,
         sif.s_ready, busy, done, err} !== '0) begin
      bad++;
      $display("FAIL reset outputs got=%b/%h/%b%b%b%b/%b%b%b%b exp=all zero", sif.x_valid,
               sif.x_data, sif.x_last_r, sif.x_last_s, sif.x_last_b, sif.x_last_i,
               sif.s_ready, busy, done, err);
    end
    rst = 1'b1; cfg_start = 1'b0; sif.s_valid = 1'b0;
    tick;
    total++;
    if (busy !== 1'b0 || sif.s_ready !== 1'b0) begin
      bad++;
      $display("FAIL reset idle busy/s_ready got=%b%b exp=00", busy, sif.s_ready);
    end
  endtask

  task automatic test_continuous;
    test_frame("cont", 4, 2, 3, 2, 1'b0, -1, -1, 1'b0, 16'h0);
  endtask

  task automatic test_stall;
    test_frame("stall", 4, 2, 3, 2, 1'b1, -1, -1, 1'b0, 16'h0);
  endtask

  task automatic test_single;
    test_frame("single", 1, 1, 1, 1, 1'b0, -1, -1, 1'b1, 16'hABCD);
  endtask

  task automatic test_mid_reset;
    pulse_cfg(4, 2, 3, 2);
    sif.x_ready = 1'b1;
    sif.s_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      sif.s_data = 16'(i);
      tick;
    end
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (sif.x_valid !== 1'b0 || sif.s_ready !== 1'b0) begin
      bad++;
      $display("FAIL midrst gate x_valid/s_ready got=%b%b exp=00", sif.x_valid, sif.s_ready);
    end
    tick;
    total++;
    if ({sif.x_valid, sif.x_data, sif.x_last_r, sif.x_last_s, sif.x_last_b, sif.x_last_i,
         busy, done, err} !== '0) begin
      bad++;
      $display("FAIL midrst outputs got=%b/%h/%b%b%b%b/%b%b%b exp=all zero", sif.x_valid,
               sif.x_data, sif.x_last_r, sif.x_last_s, sif.x_last_b, sif.x_last_i,
               busy, done, err);
    end
    rst = 1'b1;
    sif.s_valid = 1'b0;
    tick;
    test_frame("restart", 4, 2, 3, 2, 1'b0, -1, -1, 1'b0, 16'h0);
  endtask

  task automatic test_err;
    test_frame("errchk", 4, 2, 3, 2, 1'b0, 4, -1, 1'b0, 16'h0);
  endtask

  task automatic test_cfg_ignore;
    test_frame("cfgign", 4, 2, 3, 2, 1'b1, -1, 7, 1'b0, 16'h0);
  endtask

  initial begin
    sif.s_valid = 1'b0; sif.s_data = '0; sif.s_last = 1'b0; sif.x_ready = 1'b0;
    test_reset;
    test_continuous;
    test_stall;
    test_single;
    test_mid_reset;
    test_err;
    test_cfg_ignore;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
